stack_job_sched: RTL and testbench
==================================

Name: stack_job_sched

Overview:
- Scheduler that shares one stack-machine core among N requesters.
- Each requester submits a job, which is a program index. The block picks one job round-robin, pulses the core start, waits for the core's one-cycle done strobe, then returns the 8-bit result tagged with the requester id.
- Sits between the top-level control/UART sequencer (and other clients) and the stack-machine core. It replaces the hand-driven reset-to-start sequencing of the core.

Parameters:
- N, 4: number of requesters, 2..8.
- PW, 2: program-index width.
- TIMEOUT, 1024: maximum cycles in BUSY before the job is aborted; must be at least 2.
- IDW, $clog2(N): requester-id width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  N  per-requester job valid; held until accepted
- req_prog  in  N*PW  flattened program index; requester i uses bits [i*PW +: PW]
- req_ready  out  N  one-hot accept; at most one bit set
- core_start  out  1  one-cycle start pulse to the core
- core_prog  out  PW  program index presented to the core; stable from ISSUE until back in IDLE
- core_abort  out  1  one-cycle pulse on watchdog abort
- core_done  in  1  one-cycle completion strobe from the core
- core_result  in  8  core result, valid when core_done=1
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_id  out  IDW  requester that owns the response
- resp_data  out  8  result
- resp_err  out  1  1 means the job timed out

Behaviour:
- Reset: state is IDLE and the round-robin pointer is 0.
  - req_ready, core_start, core_abort and resp_valid are all 0.
  - resp_id, resp_data, resp_err and core_prog are all 0.
  - Reset mid-job drops the job silently; no response is produced.
- States and transitions:
  - IDLE: req_ready = (grant one-hot), combinational from req_valid and the pointer; the grant is nonzero only in IDLE. On any req_valid & req_ready: latch id and prog, advance pointer to id+1 mod N, go to ISSUE.
  - ISSUE: core_start=1 for exactly this cycle; go to BUSY next cycle. core_done in ISSUE is ignored.
  - BUSY: watchdog counter starts at 0 and increments each cycle.
    - If core_done: latch core_result into resp_data, set resp_err=0, go to RESP.
    - Else if counter == TIMEOUT-1: core_abort=1 this cycle, resp_data=0, resp_err=1, go to RESP.
    - If core_done and timeout coincide, core_done wins.
  - RESP: resp_valid=1, and resp_id, resp_data, resp_err are held stable until resp_ready. On resp_valid & resp_ready, return to IDLE next cycle.
- core_done outside BUSY is ignored and has no side effect.
- Latency:
  - Acceptance at cycle T; core_start at T+1.
  - core_done at cycle D (D ≥ T+2) gives resp_valid at D+1.
  - Response accepted at R; next acceptance is possible at R+1.
- Arbitration:
  - Priority order is pointer, pointer+1, … wrapping mod N.
  - A requester served once gets lowest priority next time, so no requester starves while others hold valid.
- Only one job is in flight at a time; no queueing.
- Protocol rule: requesters must not drop req_valid before acceptance. Any deassertion simply removes that requester from arbitration.

Optional Feature:
- Macro: STACK_SCHED_WATCHDOG_EN.
- Defined: TIMEOUT watchdog and core_abort behave as above.
- Undefined:
  - No counter; BUSY waits indefinitely for core_done.
  - core_abort is tied 0 and resp_err is tied 0.
  - TIMEOUT is unused.

Decomposition:
- Package stack_sched_pkg holds:
  - state encoding IDLE=0, ISSUE=1, BUSY=2, RESP=3;
  - RESULT_W=8;
  - a localparam for the default TIMEOUT.
- Sub-module rr_arbiter: N-wide combinational rotate-priority grant from req vector and pointer, producing one-hot grant and encoded id. The pointer register stays in stack_job_sched.

Test Plan (N=4, PW=2, TIMEOUT=16):
- Single job: req_valid=4'b0100 with prog=2 → req_ready=4'b0100 the same cycle; core_start one cycle later with core_prog=2. Core model asserts core_done with result 0x0A 5 cycles after start → resp_valid with id=2, data=0x0A, err=0.
- Contention: all four valid continuously, resp_ready=1 → grant order 0,1,2,3,0. Each id appears exactly once per four responses.
- Back-pressure: resp_ready=0 for 10 cycles → resp fields stable and req_ready stays 0. On resp_ready=1, next grant is issued the following cycle.
- Watchdog (macro defined): core never sends done → core_abort pulses at BUSY cycle 15, then resp_valid with err=1, data=0x00. With the macro undefined, resp_valid never asserts.
- Spurious/edge strobes:
  - core_done in ISSUE and in IDLE → ignored.
  - core_done on the same cycle as timeout → err=0 and data=core_result.
- Reset mid-BUSY: rst for 1 cycle → all outputs 0 and no response emitted. Pointer returns to 0, so requester 0 wins the next contention.

Source files
------------

// File: rtl/stack_sched_pkg.sv
// Shared types and constants for the stack-machine job scheduler.
package stack_sched_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int RESULT_W        = 8;
   localparam int DEFAULT_TIMEOUT = 1024;
endpackage

// File: rtl/stack_job_sched_rr_arbiter.sv
// Rotating-priority arbiter: the first requester at or after ptr (mod N) wins.
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   grant,
   output logic [IDW-1:0] id
);
   always_comb begin
      int  idx;
      logic found;
      grant = '0;
      id    = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            id         = IDW'(idx);
         end
      end
   end
endmodule

// File: rtl/stack_job_sched.sv
// Round-robin scheduler sharing one stack-machine core among N requesters.
// STACK_SCHED_WATCHDOG_EN enables the BUSY timeout / core_abort path.
module stack_job_sched
   import stack_sched_pkg::*;
#(
   parameter int N       = 4,
   parameter int PW      = 2,
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int IDW     = $clog2(N)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N-1:0]        req_valid,
   input  logic [N*PW-1:0]     req_prog,
   output logic [N-1:0]        req_ready,
   output logic                core_start,
   output logic [PW-1:0]       core_prog,
   output logic                core_abort,
   input  logic                core_done,
   input  logic [RESULT_W-1:0] core_result,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [IDW-1:0]      resp_id,
   output logic [RESULT_W-1:0] resp_data,
   output logic                resp_err
);
   state_t         state;
   logic [IDW-1:0] ptr;
   logic [N-1:0]   grant;
   logic [IDW-1:0] gid;
   logic           accept;
   logic           wd_hit;

   rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .id    (gid)
   );

   // Grant is only visible in IDLE so at most one job is ever in flight.
   assign req_ready  = (state == IDLE) ? grant : '0;
   assign accept     = |(req_valid & req_ready);
   assign core_start = (state == ISSUE);
   assign resp_valid = (state == RESP);

`ifdef STACK_SCHED_WATCHDOG_EN
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   logic [CW-1:0] wd_cnt;

   always_ff @(posedge clk) begin
      if (rst || state != BUSY) wd_cnt <= '0;
      else                      wd_cnt <= wd_cnt + 1'b1;
   end

   assign wd_hit     = (wd_cnt == CW'(TIMEOUT - 1));
   // core_done on the timeout cycle wins, so no abort is sent then.
   assign core_abort = (state == BUSY) && !core_done && wd_hit;
`else
   assign wd_hit     = 1'b0;
   assign core_abort = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         core_prog <= '0;
         resp_id   <= '0;
         resp_data <= '0;
         resp_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               resp_id   <= gid;
               core_prog <= req_prog[gid*PW +: PW];
               ptr       <= (gid == IDW'(N - 1)) ? '0 : gid + 1'b1;
               state     <= ISSUE;
            end
            ISSUE: state <= BUSY;
            BUSY: begin
               if (core_done) begin
                  resp_data <= core_result;
                  resp_err  <= 1'b0;
                  state     <= RESP;
               end else if (wd_hit) begin
                  resp_data <= '0;
                  resp_err  <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: if (resp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_stack_job_sched.sv
// Directed bench for stack_job_sched (N=4, PW=2, TIMEOUT=16).
module tb_stack_job_sched;
   localparam int N = 4, PW = 2, TIMEOUT = 16, IDW = 2;

   logic           clk = 0, rst = 0;
   logic [N-1:0]   req_valid = '0;
   logic [N*PW-1:0] req_prog = '0;
   logic [N-1:0]   req_ready;
   logic           core_start, core_abort, core_done = 0;
   logic [PW-1:0]  core_prog;
   logic [7:0]     core_result = '0;
   logic           resp_valid, resp_ready = 0, resp_err;
   logic [IDW-1:0] resp_id;
   logic [7:0]     resp_data;

   int tests = 0, fails = 0;

   stack_job_sched #(.N(N), .PW(PW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_prog(req_prog),
      .req_ready(req_ready), .core_start(core_start), .core_prog(core_prog),
      .core_abort(core_abort), .core_done(core_done), .core_result(core_result),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_data(resp_data), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: sim time exceeded");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1; tick(); tick(); #1;
      tests++;
      if ({req_ready, core_start, core_abort, resp_valid, resp_id, resp_data, resp_err, core_prog} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: rdy=%b st=%b ab=%b rv=%b id=%0d d=%h e=%b prog=%0d required all 0",
                  req_ready, core_start, core_abort, resp_valid, resp_id, resp_data, resp_err, core_prog);
      end
      rst = 0; tick();
   endtask

   task automatic test_single_job();
      req_valid = 4'b0100; req_prog = 8'h20; #1;
      tests++;
      if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b required 0100", req_ready); end
      tick(); req_valid = '0; #1;
      tests++;
      if (core_start !== 1'b1 || core_prog !== 2'd2) begin
         fails++; $display("FAIL single_start: start=%b prog=%0d required 1/2", core_start, core_prog);
      end
      repeat (4) tick();
      tests++;
      if (core_start !== 1'b0 || resp_valid !== 1'b0) begin
         fails++; $display("FAIL single_busy: start=%b rv=%b required 0/0", core_start, resp_valid);
      end
      tick(); core_done = 1; core_result = 8'h0A;
      tick(); core_done = 0; #1;
      tests++;
      if (resp_valid !== 1 || resp_id !== 2'd2 || resp_data !== 8'h0A || resp_err !== 0) begin
         fails++; $display("FAIL single_resp: rv=%b id=%0d d=%h e=%b required 1/2/0a/0", resp_valid, resp_id, resp_data, resp_err);
      end
      resp_ready = 1; tick(); resp_ready = 0; #1;
      tests++;
      if (resp_valid !== 1'b0) begin fails++; $display("FAIL single_release: rv=%b required 0", resp_valid); end
   endtask

   task automatic test_contention();
      int cnt [N];
      int exp_id;
      for (int i = 0; i < N; i++) cnt[i] = 0;
      rst = 1; tick(); rst = 0;
      req_valid = 4'b1111; req_prog = 8'b11_10_01_00; resp_ready = 1;
      for (int j = 0; j < 5; j++) begin
         exp_id = j % N;
         #1;
         tests++;
         if (req_ready !== 4'(1 << exp_id)) begin
            fails++; $display("FAIL contention_grant%0d: got %b required %b", j, req_ready, 4'(1 << exp_id));
         end
         tick(); tick();
         core_done = 1; core_result = 8'h10 + 8'(j);
         tick(); core_done = 0; #1;
         tests++;
         if (resp_valid !== 1 || resp_id !== IDW'(exp_id) || resp_data !== 8'h10 + 8'(j)) begin
            fails++; $display("FAIL contention_resp%0d: rv=%b id=%0d d=%h required 1/%0d/%h", j, resp_valid, resp_id, resp_data, exp_id, 8'h10 + 8'(j));
         end
         if (j < 4) cnt[resp_id] = cnt[resp_id] + 1;
         tick();
      end
      for (int i = 0; i < N; i++) begin
         tests++;
         if (cnt[i] != 1) begin fails++; $display("FAIL contention_count%0d: got %0d required 1", i, cnt[i]); end
      end
      resp_ready = 0;
   endtask

   task automatic test_back_pressure();
      // pointer sits at 1 after the 0,1,2,3,0 sequence
      req_valid = 4'b1111; #1;
      tests++;
      if (req_ready !== 4'b0010) begin fails++; $display("FAIL bp_grant: got %b required 0010", req_ready); end
      tick(); tick();
      core_done = 1; core_result = 8'h55;
      tick(); core_done = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         tests++;
         if (resp_valid !== 1 || resp_id !== 2'd1 || resp_data !== 8'h55 || resp_err !== 0 || req_ready !== 4'b0000) begin
            fails++; $display("FAIL bp_hold%0d: rv=%b id=%0d d=%h e=%b rdy=%b required 1/1/55/0/0000", c, resp_valid, resp_id, resp_data, resp_err, req_ready);
         end
         tick();
      end
      resp_ready = 1; tick(); #1;
      tests++;
      if (req_ready !== 4'b0100) begin fails++; $display("FAIL bp_next_grant: got %b required 0100", req_ready); end
      tick(); req_valid = '0;
      tick(); core_done = 1; core_result = 8'h01;
      tick(); core_done = 0; tick(); resp_ready = 0;
   endtask

   task automatic test_watchdog();
      req_valid = 4'b0001; #1;
      tick(); req_valid = '0;
      tick();
      for (int i = 0; i < TIMEOUT - 1; i++) begin
         tests++;
         if (core_abort !== 1'b0) begin fails++; $display("FAIL wd_early_abort%0d: got %b required 0", i, core_abort); end
         tick();
      end
      resp_ready = 1; #1;
`ifdef STACK_SCHED_WATCHDOG_EN
      tests++;
      if (core_abort !== 1'b1) begin fails++; $display("FAIL wd_abort: got %b required 1", core_abort); end
      tick();
      tests++;
      if (resp_valid !== 1 || resp_err !== 1 || resp_data !== 8'h00 || core_abort !== 0) begin
         fails++; $display("FAIL wd_resp: rv=%b e=%b d=%h ab=%b required 1/1/00/0", resp_valid, resp_err, resp_data, core_abort);
      end
      tick();
`else
      for (int i = 0; i < 20; i++) begin
         tests++;
         if (resp_valid !== 1'b0 || core_abort !== 1'b0) begin
            fails++; $display("FAIL wd_disabled%0d: rv=%b ab=%b required 0/0", i, resp_valid, core_abort);
         end
         tick();
      end
      rst = 1; tick(); rst = 0;
`endif
      resp_ready = 0;
   endtask

   task automatic test_spurious();
      core_done = 1; core_result = 8'hEE;
      tick(); core_done = 0; tick();
      tests++;
      if (resp_valid !== 1'b0) begin fails++; $display("FAIL spur_idle: rv=%b required 0", resp_valid); end
      req_valid = 4'b0100; req_prog = 8'h10;
      tick(); req_valid = '0;
      core_done = 1; core_result = 8'hEE;
      tick(); core_done = 0; #1;
      tests++;
      if (resp_valid !== 1'b0 || core_prog !== 2'd1) begin
         fails++; $display("FAIL spur_issue: rv=%b prog=%0d required 0/1", resp_valid, core_prog);
      end
      repeat (TIMEOUT - 1) tick();
      core_done = 1; core_result = 8'h3C; #1;
      tests++;
      if (core_abort !== 1'b0) begin fails++; $display("FAIL edge_abort: got %b required 0", core_abort); end
      tick(); core_done = 0; #1;
      tests++;
      if (resp_valid !== 1 || resp_err !== 0 || resp_data !== 8'h3C || resp_id !== 2'd2) begin
         fails++; $display("FAIL edge_resp: rv=%b e=%b d=%h id=%0d required 1/0/3c/2", resp_valid, resp_err, resp_data, resp_id);
      end
      resp_ready = 1; tick(); resp_ready = 0;
   endtask

   task automatic test_reset_mid_busy();
      req_valid = 4'b0001; req_prog = 8'h03;
      tick(); req_valid = '0;
      tick(); tick(); tick();
      rst = 1; tick(); rst = 0; #1;
      tests++;
      if ({req_ready, core_start, core_abort, resp_valid, resp_id, resp_data, resp_err, core_prog} !== '0) begin
         fails++; $display("FAIL midrst_outputs: rdy=%b st=%b ab=%b rv=%b id=%0d d=%h e=%b prog=%0d required all 0",
                           req_ready, core_start, core_abort, resp_valid, resp_id, resp_data, resp_err, core_prog);
      end
      core_done = 1; core_result = 8'h77; resp_ready = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         core_done = 0;
         tests++;
         if (resp_valid !== 1'b0) begin fails++; $display("FAIL midrst_noresp%0d: rv=%b required 0", i, resp_valid); end
      end
      req_valid = 4'b1111; #1;
      tests++;
      if (req_ready !== 4'b0001) begin fails++; $display("FAIL midrst_ptr: got %b required 0001", req_ready); end
      tick(); req_valid = '0;
      tick(); core_done = 1; core_result = 8'h42;
      tick(); core_done = 0; #1;
      tests++;
      if (resp_valid !== 1 || resp_id !== 2'd0 || resp_data !== 8'h42) begin
         fails++; $display("FAIL midrst_job: rv=%b id=%0d d=%h required 1/0/42", resp_valid, resp_id, resp_data);
      end
      tick(); resp_ready = 0;
   endtask

   initial begin
      test_reset();
      test_single_job();
      test_contention();
      test_back_pressure();
      test_watchdog();
      test_spurious();
      test_reset_mid_busy();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
